// File: rtl/tone_sweep_gen_if.sv
// Control, configuration and sample-output bundle for tone_sweep_gen.
// The master side drives strobes and configuration; the slave side (the
// generator) returns samples, status and the active tuning word.
interface tone_sweep_gen_if #(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 12
);
    logic               sample_en;
    logic               start;
    logic               abort;
    logic               mode;
    logic [PHASE_W-1:0] freq_start;
    logic [PHASE_W-1:0] freq_step;
    logic [PHASE_W-1:0] freq_stop;
    logic [31:0]        dwell;
    logic [OUT_W-1:0]   out_val;
    logic               out_valid;
    logic               busy;
    logic               done;
    logic [PHASE_W-1:0] cur_freq;

    modport master (
        output sample_en, start, abort, mode, freq_start, freq_step, freq_stop, dwell,
        input  out_val, out_valid, busy, done, cur_freq
    );

    modport slave (
        input  sample_en, start, abort, mode, freq_start, freq_step, freq_stop, dwell,
        output out_val, out_valid, busy, done, cur_freq
    );
endinterface

// File: rtl/tone_sweep_gen.sv
// Direct digital synthesis sine source with an optional stepped frequency
// sweep. A phase accumulator addresses a quarter-wave sine ROM; quadrant
// bits select index mirroring and sign. One sample is produced per accepted
// sample_en strobe, two clocks after the strobe.
module tone_sweep_gen #(
    parameter int PHASE_W    = 32,
    parameter int LUT_BITS   = 8,
    parameter int OUT_W      = 12,
    parameter bit OFFSET_BIN = 1'b1,
    parameter bit SWEEP_WRAP = 1'b0
) (
    input logic             clk,
    input logic             reset,
    tone_sweep_gen_if.slave bus
);
    localparam int  ROM_DEPTH = 1 << LUT_BITS;
    localparam int  AMP       = (1 << (OUT_W - 1)) - 1;
    localparam real PI        = 3.14159265358979323846;
    localparam logic [OUT_W-1:0] OUT_RESET = OFFSET_BIN ? OUT_W'(AMP) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // Latched configuration
    logic               r_mode;
    logic [PHASE_W-1:0] r_freqStart;
    logic [PHASE_W-1:0] r_freqStep;
    logic [PHASE_W-1:0] r_freqStop;
    logic [31:0]        r_dwell;

    // Accumulator and sweep control
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_curFreq;
    logic [31:0]        r_dwellCnt;
    logic               r_finish;

    // Sample pipeline
    logic [OUT_W-2:0]   r_romData;
    logic               r_neg;
    logic               r_stageValid;
    logic [OUT_W-1:0]   r_outVal;
    logic               r_outValid;

    logic [OUT_W-2:0]    w_rom [ROM_DEPTH];
    logic                w_startCmd;
    logic                w_accept;
    logic                w_stepDue;
    logic                w_overStop;
    logic [PHASE_W:0]    w_nextFreq;
    logic [1:0]          w_quad;
    logic [LUT_BITS-1:0] w_idx;
    logic [LUT_BITS-1:0] w_romAddr;
    logic [OUT_W-1:0]    w_magnitude;
    logic [OUT_W-1:0]    w_signed;
    logic [OUT_W-1:0]    w_formatted;

    // Quarter-wave table, sampled at bin centres so the mirrored quadrants
    // never repeat an endpoint; values are fixed at elaboration time.
    for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
        localparam int ROM_INT =
            $rtoi(AMP * $sin(PI * (2.0 * gi + 1.0) / (4.0 * ROM_DEPTH)) + 0.5);
        assign w_rom[gi] = ROM_INT[OUT_W-2:0];
    end

    // start is ignored during the single DONE cycle and loses to abort.
    assign w_startCmd = bus.start && !bus.abort && (r_state != ST_DONE);
    assign w_accept   = bus.sample_en && (r_state == ST_RUN) && !r_finish &&
                        !bus.start && !bus.abort;

    assign w_stepDue  = (r_dwellCnt == r_dwell - 32'd1);
    assign w_nextFreq = {1'b0, r_curFreq} + {1'b0, r_freqStep};
    assign w_overStop = (w_nextFreq > {1'b0, r_freqStop});

    assign w_quad    = r_phase[PHASE_W-1 -: 2];
    assign w_idx     = r_phase[PHASE_W-3 -: LUT_BITS];
    assign w_romAddr = w_quad[0] ? ~w_idx : w_idx;

    assign w_magnitude = {1'b0, r_romData};
    assign w_signed    = r_neg ? -w_magnitude : w_magnitude;
    assign w_formatted = OFFSET_BIN ? (w_signed + OUT_W'(AMP)) : w_signed;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: a finishing sweep waits in RUN until the last
    // accepted sample has left the ROM stage, then shows DONE for one cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: w_nextState = ST_IDLE;
            ST_RUN: begin
                if (r_finish && !r_stageValid) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
        if (w_startCmd) begin
            w_nextState = ST_RUN;
        end
        if (bus.abort) begin
            w_nextState = ST_IDLE;
        end
    end

    // Configuration latch, phase accumulator and sweep stepping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode      <= 1'b0;
            r_freqStart <= '0;
            r_freqStep  <= '0;
            r_freqStop  <= '0;
            r_dwell     <= 32'd1;
            r_phase     <= '0;
            r_curFreq   <= '0;
            r_dwellCnt  <= '0;
            r_finish    <= 1'b0;
        end else if (bus.abort) begin
            r_finish <= 1'b0;
        end else if (w_startCmd) begin
            r_mode      <= bus.mode;
            r_freqStart <= bus.freq_start;
            r_freqStep  <= bus.freq_step;
            r_freqStop  <= bus.freq_stop;
            r_dwell     <= (bus.dwell == 32'd0) ? 32'd1 : bus.dwell;
            r_phase     <= '0;
            r_curFreq   <= bus.freq_start;
            r_dwellCnt  <= '0;
            r_finish    <= 1'b0;
        end else if (w_accept) begin
            r_phase <= r_phase + r_curFreq;
            if (r_mode) begin
                if (w_stepDue) begin
                    r_dwellCnt <= '0;
                    if (!w_overStop) begin
                        r_curFreq <= w_nextFreq[PHASE_W-1:0];
                    end else if (SWEEP_WRAP) begin
                        r_curFreq <= r_freqStart;
                    end else begin
                        r_finish <= 1'b1;
                    end
                end else begin
                    r_dwellCnt <= r_dwellCnt + 32'd1;
                end
            end
        end
    end

    // Two-stage sample pipeline: registered ROM read, then sign/format;
    // abort drops anything still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_romData    <= '0;
            r_neg        <= 1'b0;
            r_stageValid <= 1'b0;
            r_outVal     <= OUT_RESET;
            r_outValid   <= 1'b0;
        end else begin
            r_stageValid <= w_accept;
            r_outValid   <= r_stageValid && !bus.abort;
            if (w_accept) begin
                r_romData <= w_rom[w_romAddr];
                r_neg     <= w_quad[1];
            end
            if (r_stageValid && !bus.abort) begin
                r_outVal <= w_formatted;
            end
        end
    end

    assign bus.out_val   = r_outVal;
    assign bus.out_valid = r_outValid;
    assign bus.busy      = (r_state == ST_RUN);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.cur_freq  = r_curFreq;
endmodule

// File: tb/tb_tone_sweep_gen.sv
// Directed bench for tone_sweep_gen. Three instances share one stimulus:
// A = offset binary / no wrap, B = offset binary / wrap, C = signed / no wrap.
module tb_tone_sweep_gen;
    localparam int PHASE_W  = 32;
    localparam int LUT_BITS = 8;
    localparam int OUT_W    = 12;
    localparam logic [31:0] F26 = 32'h0400_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        sampleEn;
    logic        startP;
    logic        abortP;
    logic        modeSel;
    logic [31:0] fStart;
    logic [31:0] fStep;
    logic [31:0] fStop;
    logic [31:0] dwellV;

    int testsRun    = 0;
    int testsFailed = 0;

    tone_sweep_gen_if #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) busA ();
    tone_sweep_gen_if #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) busB ();
    tone_sweep_gen_if #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) busC ();

    assign busA.sample_en = sampleEn;
    assign busA.start = startP;
    assign busA.abort = abortP;
    assign busA.mode = modeSel;
    assign busA.freq_start = fStart;
    assign busA.freq_step = fStep;
    assign busA.freq_stop = fStop;
    assign busA.dwell = dwellV;

    assign busB.sample_en = sampleEn;
    assign busB.start = startP;
    assign busB.abort = abortP;
    assign busB.mode = modeSel;
    assign busB.freq_start = fStart;
    assign busB.freq_step = fStep;
    assign busB.freq_stop = fStop;
    assign busB.dwell = dwellV;

    assign busC.sample_en = sampleEn;
    assign busC.start = startP;
    assign busC.abort = abortP;
    assign busC.mode = modeSel;
    assign busC.freq_start = fStart;
    assign busC.freq_step = fStep;
    assign busC.freq_stop = fStop;
    assign busC.dwell = dwellV;

    tone_sweep_gen #(.PHASE_W(PHASE_W), .LUT_BITS(LUT_BITS), .OUT_W(OUT_W),
                     .OFFSET_BIN(1'b1), .SWEEP_WRAP(1'b0))
        dutA (.clk(clk), .reset(reset), .bus(busA));
    tone_sweep_gen #(.PHASE_W(PHASE_W), .LUT_BITS(LUT_BITS), .OUT_W(OUT_W),
                     .OFFSET_BIN(1'b1), .SWEEP_WRAP(1'b1))
        dutB (.clk(clk), .reset(reset), .bus(busB));
    tone_sweep_gen #(.PHASE_W(PHASE_W), .LUT_BITS(LUT_BITS), .OUT_W(OUT_W),
                     .OFFSET_BIN(1'b0), .SWEEP_WRAP(1'b0))
        dutC (.clk(clk), .reset(reset), .bus(busC));

    always #5 clk = ~clk;

    // Advance one full clock and land on the falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold the given control pulses for exactly one rising edge.
    task automatic applyStimulus(input logic st, input logic ab, input logic se);
        startP   = st;
        abortP   = ab;
        sampleEn = se;
        tick();
        startP   = 1'b0;
        abortP   = 1'b0;
        sampleEn = 1'b0;
    endtask

    task automatic configure(input logic m, input logic [31:0] fs, input logic [31:0] st,
                             input logic [31:0] sp, input logic [31:0] dw);
        modeSel = m;
        fStart  = fs;
        fStep   = st;
        fStop   = sp;
        dwellV  = dw;
    endtask

    task automatic test_reset();
        testsRun++;
        if (busA.out_val !== 12'd2047 || busA.out_valid !== 1'b0 || busA.busy !== 1'b0 ||
            busA.done !== 1'b0 || busA.cur_freq !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_state_A: val=%0d valid=%b busy=%b done=%b freq=%h, want 2047 0 0 0 0",
                     busA.out_val, busA.out_valid, busA.busy, busA.done, busA.cur_freq);
        end
        testsRun++;
        if (busC.out_val !== 12'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_state_C: val=%0d, want 0", busC.out_val);
        end
        configure(1'b0, F26, 32'd0, 32'd0, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        testsRun++;
        if (busA.out_valid !== 1'b0 || busA.busy !== 1'b0 || busA.cur_freq !== 32'd0 ||
            busA.out_val !== 12'd2047) begin
            testsFailed++;
            $display("[TB] FAIL reset_midrun: valid=%b busy=%b freq=%h val=%0d, want 0 0 0 2047",
                     busA.out_valid, busA.busy, busA.cur_freq, busA.out_val);
        end
        tick();
        testsRun++;
        if (busA.out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_no_partial: valid=%b, want 0", busA.out_valid);
        end
    endtask

    task automatic test_fixed_tone();
        logic [11:0] samples [65];
        int expVal [4] = '{2053, 4094, 2041, 0};
        configure(1'b0, F26, 32'd0, 32'd0, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        testsRun++;
        if (busA.busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL fixed_busy: busy=%b, want 1", busA.busy);
        end
        for (int k = 0; k < 65; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            testsRun++;
            if (busA.out_valid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL fixed_latency_early k=%0d: valid=%b, want 0", k, busA.out_valid);
            end
            tick();
            testsRun++;
            if (busA.out_valid !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL fixed_latency k=%0d: valid=%b, want 1", k, busA.out_valid);
            end
            samples[k] = busA.out_val;
            tick();
            tick();
        end
        for (int j = 0; j < 4; j++) begin
            testsRun++;
            if (samples[j*16] !== 12'(expVal[j])) begin
                testsFailed++;
                $display("[TB] FAIL fixed_sample_%0d: got %0d, want %0d", j*16, samples[j*16], expVal[j]);
            end
        end
        testsRun++;
        if (samples[64] !== 12'd2053) begin
            testsFailed++;
            $display("[TB] FAIL fixed_period: sample64=%0d, want 2053", samples[64]);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] expFreq;
        configure(1'b1, F26, F26, 32'h1000_0000, 32'd4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            expFreq = F26 * 32'(k / 4 + 1);
            testsRun++;
            if (busA.cur_freq !== expFreq) begin
                testsFailed++;
                $display("[TB] FAIL sweep_freq k=%0d: got %h, want %h", k, busA.cur_freq, expFreq);
            end
            applyStimulus(1'b0, 1'b0, 1'b1);
            tick();
            testsRun++;
            if (busA.out_valid !== 1'b1 || busA.done !== 1'b0 || busA.busy !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL sweep_sample k=%0d: valid=%b done=%b busy=%b, want 1 0 1",
                         k, busA.out_valid, busA.done, busA.busy);
            end
        end
        tick();
        testsRun++;
        if (busA.done !== 1'b1 || busA.busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL sweep_done: done=%b busy=%b, want 1 0", busA.done, busA.busy);
        end
        tick();
        testsRun++;
        if (busA.done !== 1'b0 || busA.busy !== 1'b0 || busA.cur_freq !== 32'h1000_0000) begin
            testsFailed++;
            $display("[TB] FAIL sweep_after: done=%b busy=%b freq=%h, want 0 0 10000000",
                     busA.done, busA.busy, busA.cur_freq);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] expFreq;
        configure(1'b1, F26, F26, 32'h1000_0000, 32'd4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 18; k++) begin
            expFreq = F26 * 32'((k % 16) / 4 + 1);
            testsRun++;
            if (busB.cur_freq !== expFreq) begin
                testsFailed++;
                $display("[TB] FAIL wrap_freq k=%0d: got %h, want %h", k, busB.cur_freq, expFreq);
            end
            applyStimulus(1'b0, 1'b0, 1'b1);
            tick();
            testsRun++;
            if (busB.out_valid !== 1'b1 || busB.done !== 1'b0 || busB.busy !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL wrap_status k=%0d: valid=%b done=%b busy=%b, want 1 0 1",
                         k, busB.out_valid, busB.done, busB.busy);
            end
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_priority();
        configure(1'b0, F26, 32'd0, 32'd0, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        testsRun++;
        if (busA.out_valid !== 1'b0 || busA.busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL prio_abort: valid=%b busy=%b, want 0 0", busA.out_valid, busA.busy);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            tick();
            testsRun++;
            if (busA.out_valid !== 1'b0 || busA.busy !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL prio_idle k=%0d: valid=%b busy=%b, want 0 0", k, busA.out_valid, busA.busy);
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        testsRun++;
        if (busA.out_valid !== 1'b1 || busA.out_val !== 12'd2053) begin
            testsFailed++;
            $display("[TB] FAIL prio_restart: valid=%b val=%0d, want 1 2053", busA.out_valid, busA.out_val);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_signed();
        logic signed [11:0] samples [49];
        int expVal [4] = '{6, 2047, -6, -2047};
        configure(1'b0, F26, 32'd0, 32'd0, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 49; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            tick();
            samples[k] = $signed(busC.out_val);
            tick();
            tick();
        end
        for (int j = 0; j < 4; j++) begin
            testsRun++;
            if (samples[j*16] !== 12'(expVal[j])) begin
                testsFailed++;
                $display("[TB] FAIL signed_sample_%0d: got %0d, want %0d", j*16, samples[j*16], expVal[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic expValid;
        configure(1'b0, F26, 32'd0, 32'd0, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            sampleEn = (i <= 4);
            tick();
            expValid = (i >= 2 && i <= 5);
            testsRun++;
            if (busC.out_valid !== expValid) begin
                testsFailed++;
                $display("[TB] FAIL b2b_valid i=%0d: got %b, want %b", i, busC.out_valid, expValid);
            end
            if (i == 2) begin
                testsRun++;
                if ($signed(busC.out_val) !== 12'sd6) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_first: got %0d, want 6", $signed(busC.out_val));
                end
            end
        end
        sampleEn = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);
    endtask

    // Guard against a stuck run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        reset    = 1'b1;
        sampleEn = 1'b0;
        startP   = 1'b0;
        abortP   = 1'b0;
        configure(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_fixed_tone();
        test_sweep();
        test_wrap();
        test_priority();
        test_signed();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/tone_sweep_gen.md
Name: tone_sweep_gen

Overview:
- Parametrised direct digital synthesis (DDS) sine source that replaces behavioural tone stimulus with synthesizable logic.
- Produces one sine sample per sample-rate strobe, in signed or offset-binary format, at a programmable tuning word.
- Optional stepped frequency sweep: start, step, stop and dwell are all programmable.
- Feeds fir_filter idata inputs in hardware self-test and in bench regressions.

Parameters:
- PHASE_W, 32, phase accumulator and tuning-word width.
- LUT_BITS, 8, log2 of quarter-wave ROM depth.
- OUT_W, 12, output sample width.
- OFFSET_BIN, 1, output format: 1 = offset binary (s + 2^(OUT_W-1) - 1), 0 = two's-complement signed s.
- SWEEP_WRAP, 0, sweep end behaviour: 1 = restart at freq_start instead of finishing.

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- sample_en  in  1  one-cycle sample-rate strobe.
- start  in  1  one-cycle pulse: latch configuration, clear phase, begin.
- abort  in  1  one-cycle pulse: return to IDLE.
- mode  in  1  0 = fixed tone, 1 = sweep.
- freq_start  in  PHASE_W  initial tuning word.
- freq_step  in  PHASE_W  sweep increment.
- freq_stop  in  PHASE_W  sweep upper bound, inclusive.
- dwell  in  32  samples per sweep step; value 0 is treated as 1.
- out_val  out  OUT_W  sine sample.
- out_valid  out  1  one-cycle qualifier for out_val.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at sweep completion.
- cur_freq  out  PHASE_W  active tuning word.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset clears everything: state = IDLE, phase = 0, cur_freq = 0, dwell counter = 0, out_valid = 0, busy = 0, done = 0.
  - out_val resets to 0, or to 2^(OUT_W-1) - 1 when OFFSET_BIN = 1.
  - Reset mid-run behaves identically, with no partial sample emitted.
- States: IDLE, RUN, DONE.
  - IDLE + start: latch all config inputs, phase = 0, cur_freq = freq_start, dwell counter = 0, go to RUN.
  - RUN + start: restart with the same actions as from IDLE.
  - abort has priority over start. Any state + abort goes to IDLE; in-flight pipeline samples are dropped.
  - DONE lasts exactly one cycle: done = 1, then IDLE.
- Sample pipeline (RUN only, per sample_en):
  - Cycle 0: address the ROM from the current phase, then phase += cur_freq (mod 2^PHASE_W).
  - Cycle 1: registered ROM read.
  - Cycle 2: sign/mirror/format applied; out_val registered, out_valid = 1.
  - Latency is 2 clocks from sample_en to out_valid. First sample after start uses phase 0.
  - sample_en outside RUN is ignored.
  - sample_en on consecutive cycles is legal, giving full-rate output.
- Quarter-wave mapping:
  - q = phase[PHASE_W-1:PHASE_W-2]; idx = next LUT_BITS bits.
  - q = 1 or 3: ROM index = ~idx.
  - q = 2 or 3: s = -ROM.
  - ROM[i] = round((2^(OUT_W-1) - 1) * sin(pi/2 * (i + 0.5) / 2^LUT_BITS)), held internally, unsigned OUT_W-1 bits. Output never equals -(2^(OUT_W-1)).
- Sweep (mode = 1):
  - The dwell counter counts accepted sample_en strobes.
  - When the count reaches dwell - 1: clear the counter and compute nf = cur_freq + freq_step with a PHASE_W+1-bit sum.
  - If nf <= freq_stop: cur_freq = nf.
  - Otherwise, SWEEP_WRAP = 0: go to DONE after the last sample drains from the pipeline. SWEEP_WRAP = 1: cur_freq = freq_start, phase continues.
  - freq_step = 0 never terminates; this is legal.
- Fixed mode (mode = 0): cur_freq constant, runs until abort or start.
- busy = (state == RUN).

Test Plan:
- Fixed tone: mode = 0, freq_start = 2^26, OFFSET_BIN = 1, sample_en every 4 clocks.
  - Samples 0/16/32/48 = 2053 / 4094 / 2041 / 0.
  - Period is 64 samples.
  - out_valid is 2 clocks after each strobe.
- Sweep: freq_start = 2^26, freq_step = 2^26, freq_stop = 2^28, dwell = 4.
  - cur_freq steps 2^26, 2^27, 3*2^26, 2^28, each held for 4 samples.
  - done pulses once after the 16th out_valid; busy then falls.
- Wrap: same sweep with SWEEP_WRAP = 1. After 16 samples cur_freq returns to 2^26, done never asserts, busy stays 1.
- Control priority: abort and start in the same cycle mid-run leads to IDLE, with no further out_valid. A later start restarts at phase 0 (first sample 2053).
- Reset: synchronous reset mid-run clears out_valid, busy and cur_freq next cycle; out_val = 2047.
- Signed mode: OFFSET_BIN = 0 with the same fixed-tone stimulus gives samples 6 / 2047 / -6 / -2047. Back-to-back sample_en produces back-to-back out_valid.
